// File: rtl/input_sram_loader.sv
// Packs a host byte stream of square matrices into the input SRAM image:
// per matrix a header {8'h00, N} and N*N/2 two-pixel words, then a 16'hFFFF terminator.
module input_sram_loader #(
    parameter int unsigned MAX_N     = 64,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        load_start,
    input  logic        load_finish,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        loader_busy,
    output logic        loader_done,
    output logic        loader_error,
    output logic [7:0]  matrix_count,
    output logic        input_sram_write_enable,
    output logic [11:0] input_sram_write_addresss,
    output logic [15:0] input_sram_write_data
);
    localparam int unsigned AW    = 12;
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned PW    = 15;
    localparam int unsigned SW    = 17;
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_N,
        ST_PIX_HI,
        ST_PIX_LO,
        ST_TERM,
        ST_ERR
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    // r_addr is one bit wider than the SRAM address so "all 4096 words used" is representable
    logic [CW-1:0]   r_addr;
    logic [PW-1:0]   r_words_left;
    logic [7:0]      r_hi;
    logic [7:0]      r_count;
    logic            r_error;
    logic            r_done;
    logic            r_we;
    logic [AW-1:0]   r_waddr;
    logic [15:0]     r_wdata;

    logic [CW-1:0]   w_addr_nxt;
    logic [PW-1:0]   w_words_nxt;
    logic [7:0]      w_hi_nxt;
    logic [7:0]      w_count_nxt;
    logic            w_error_nxt;
    logic            w_done_nxt;
    logic            w_we_nxt;
    logic [AW-1:0]   w_waddr_nxt;
    logic [15:0]     w_wdata_nxt;
    logic            w_s_ready;

    logic [PW-1:0]   w_payload;
    logic [SW-1:0]   w_need;
    logic [SW-1:0]   w_room;
    logic            w_full;
    logic            w_hdr_ok;
    logic [7:0]      w_count_inc;

    // Header legality: even N in [4, MAX_N] and header + payload + terminator must still fit
    assign w_payload   = PW'((16'(s_data) * 16'(s_data)) >> 1);
    assign w_need      = SW'(w_payload) + SW'(2);
    assign w_room      = SW'(DEPTH) - SW'(r_addr);
    assign w_full      = r_addr[AW];
    assign w_hdr_ok    = ~s_data[0] && (s_data >= 8'd4) && (s_data <= 8'(MAX_N)) &&
                         (w_need <= w_room);
    assign w_count_inc = (r_count == 8'hFF) ? r_count : r_count + 8'd1;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_words_nxt = r_words_left;
        w_hi_nxt    = r_hi;
        w_count_nxt = r_count;
        w_error_nxt = r_error;
        w_done_nxt  = 1'b0;
        w_we_nxt    = 1'b0;
        w_waddr_nxt = r_waddr;
        w_wdata_nxt = r_wdata;
        w_s_ready   = 1'b0;

        case (r_state)
            ST_IDLE, ST_ERR: begin
                if (load_start) begin
                    w_state_nxt = ST_GET_N;
                    w_addr_nxt  = CW'(BASE_ADDR);
                    w_count_nxt = 8'd0;
                    w_error_nxt = 1'b0;
                end
            end
            ST_GET_N: begin
                w_s_ready = ~load_finish;
                if (load_finish) begin
                    if (w_full) begin
                        w_state_nxt = ST_ERR;
                        w_error_nxt = 1'b1;
                    end else begin
                        w_we_nxt    = 1'b1;
                        w_waddr_nxt = r_addr[AW-1:0];
                        w_wdata_nxt = 16'hFFFF;
                        w_addr_nxt  = r_addr + CW'(1);
                        w_state_nxt = ST_TERM;
                    end
                end else if (s_valid) begin
                    if (w_hdr_ok) begin
                        w_we_nxt    = 1'b1;
                        w_waddr_nxt = r_addr[AW-1:0];
                        w_wdata_nxt = {8'h00, s_data};
                        w_addr_nxt  = r_addr + CW'(1);
                        w_words_nxt = w_payload;
                        w_state_nxt = ST_PIX_HI;
                    end else begin
                        w_state_nxt = ST_ERR;
                        w_error_nxt = 1'b1;
                    end
                end
            end
            ST_PIX_HI: begin
                w_s_ready = 1'b1;
                if (load_finish) begin
                    w_state_nxt = ST_ERR;
                    w_error_nxt = 1'b1;
                end else if (s_valid) begin
                    w_hi_nxt    = s_data;
                    w_state_nxt = ST_PIX_LO;
                end
            end
            ST_PIX_LO: begin
                w_s_ready = 1'b1;
                if (load_finish || (s_valid && w_full)) begin
                    w_state_nxt = ST_ERR;
                    w_error_nxt = 1'b1;
                end else if (s_valid) begin
                    w_we_nxt    = 1'b1;
                    w_waddr_nxt = r_addr[AW-1:0];
                    w_wdata_nxt = {r_hi, s_data};
                    w_addr_nxt  = r_addr + CW'(1);
                    w_words_nxt = r_words_left - PW'(1);
                    if (r_words_left == PW'(1)) begin
                        w_count_nxt = w_count_inc;
                        w_state_nxt = ST_GET_N;
                    end else begin
                        w_state_nxt = ST_PIX_HI;
                    end
                end
            end
            ST_TERM: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_addr       <= '0;
            r_words_left <= '0;
            r_hi         <= '0;
            r_count      <= '0;
            r_error      <= 1'b0;
            r_done       <= 1'b0;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
        end else begin
            r_addr       <= w_addr_nxt;
            r_words_left <= w_words_nxt;
            r_hi         <= w_hi_nxt;
            r_count      <= w_count_nxt;
            r_error      <= w_error_nxt;
            r_done       <= w_done_nxt;
            r_we         <= w_we_nxt;
            r_waddr      <= w_waddr_nxt;
            r_wdata      <= w_wdata_nxt;
        end
    end

    assign s_ready                   = w_s_ready;
    assign loader_busy               = (r_state == ST_GET_N) || (r_state == ST_PIX_HI) ||
                                       (r_state == ST_PIX_LO) || (r_state == ST_TERM);
    assign loader_done               = r_done;
    assign loader_error              = r_error;
    assign matrix_count              = r_count;
    assign input_sram_write_enable   = r_we;
    assign input_sram_write_addresss = r_waddr;
    assign input_sram_write_data     = r_wdata;

endmodule

// File: tb/tb_input_sram_loader.sv
// Self-checking bench for input_sram_loader: header legality table, directed corner
// sequences and randomized streams checked against a byte-stream-to-image reference packer.
module tb_input_sram_loader;
    localparam int BASE = 0;

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        load_start = 1'b0;
    logic        load_finish = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready;
    logic        loader_busy;
    logic        loader_done;
    logic        loader_error;
    logic [7:0]  matrix_count;
    logic        we;
    logic [11:0] waddr;
    logic [15:0] wdata;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int cyc = 0;

    logic [11:0] log_a[$];
    logic [15:0] log_d[$];
    logic [7:0]  stream[$];
    logic [11:0] exp_a[$];
    logic [15:0] exp_d[$];
    int          exp_mats;

    typedef struct {
        logic [7:0] n;
        logic       exp_err;
    } hdr_vec_t;

    input_sram_loader dut (
        .clk                       (clk),
        .reset_b                   (reset_b),
        .load_start                (load_start),
        .load_finish               (load_finish),
        .s_valid                   (s_valid),
        .s_data                    (s_data),
        .s_ready                   (s_ready),
        .loader_busy               (loader_busy),
        .loader_done               (loader_done),
        .loader_error              (loader_error),
        .matrix_count              (matrix_count),
        .input_sram_write_enable   (we),
        .input_sram_write_addresss (waddr),
        .input_sram_write_data     (wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // SRAM write / done monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (we) begin
            log_a.push_back(waddr);
            log_d.push_back(wdata);
        end
        if (loader_done) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        log_a.delete();
        log_d.delete();
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic finish_image();
        load_finish = 1'b1;
        step();
        load_finish = 1'b0;
        wait_cycles(3);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        guard = 0;
        repeat (gap) begin
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            step();
        end
        s_valid = 1'b1;
        s_data  = b;
        #0;
        while (!s_ready && guard < 50) begin
            step();
            guard++;
        end
        if (guard >= 50) chk("send_timeout", 1, 0);
        step();
        s_valid = 1'b0;
    endtask

    task automatic run_stream(input int gap_max);
        pulse_start();
        foreach (stream[i]) send_byte(stream[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
        finish_image();
    endtask

    task automatic add_matrix(input int n, input int force_edge);
        stream.push_back(8'(n));
        for (int k = 0; k < n * n; k++) begin
            if (force_edge != 0 && k == 0)      stream.push_back(8'h80);
            else if (force_edge != 0 && k == 1) stream.push_back(8'h7F);
            else                                stream.push_back(8'($urandom));
        end
    endtask

    // Reference packer: walks the byte stream as header/pixel groups and lays out words sequentially
    function automatic void build_expected();
        int idx;
        int addr;
        int n;
        idx  = 0;
        addr = BASE;
        exp_a.delete();
        exp_d.delete();
        exp_mats = 0;
        while (idx < stream.size()) begin
            n = int'(stream[idx]);
            idx++;
            exp_a.push_back(12'(addr));
            exp_d.push_back({8'h00, 8'(n)});
            addr++;
            for (int k = 0; k < n * n / 2; k++) begin
                exp_a.push_back(12'(addr));
                exp_d.push_back({stream[idx], stream[idx + 1]});
                idx  += 2;
                addr++;
            end
            exp_mats++;
        end
        exp_a.push_back(12'(addr));
        exp_d.push_back(16'hFFFF);
    endfunction

    task automatic compare_log(input string name);
        int mism;
        int first;
        int lim;
        mism  = 0;
        first = -1;
        chk({name, "_nwrites"}, log_a.size(), exp_a.size());
        lim = (log_a.size() < exp_a.size()) ? log_a.size() : exp_a.size();
        for (int i = 0; i < lim; i++) begin
            if (log_a[i] !== exp_a[i] || log_d[i] !== exp_d[i]) begin
                mism++;
                if (first < 0) first = i;
            end
        end
        total++;
        if (mism != 0) begin
            bad++;
            $display("FAIL %s_image: %0d differing writes, first #%0d got @%0h=%04h expected @%0h=%04h",
                     name, mism, first, log_a[first], log_d[first], exp_a[first], exp_d[first]);
        end
    endtask

    hdr_vec_t hv[12];

    initial begin
        int d0;
        int c0;

        hv[0]  = '{8'd4,   1'b0};
        hv[1]  = '{8'd5,   1'b1};
        hv[2]  = '{8'd66,  1'b1};
        hv[3]  = '{8'd2,   1'b1};
        hv[4]  = '{8'd0,   1'b1};
        hv[5]  = '{8'd64,  1'b0};
        hv[6]  = '{8'd6,   1'b0};
        hv[7]  = '{8'd126, 1'b1};
        hv[8]  = '{8'd65,  1'b1};
        hv[9]  = '{8'd255, 1'b1};
        hv[10] = '{8'd3,   1'b1};
        hv[11] = '{8'd62,  1'b0};

        // reset state
        wait_cycles(3);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_busy", loader_busy, 0);
        chk("rst_done", loader_done, 0);
        chk("rst_error", loader_error, 0);
        chk("rst_count", matrix_count, 0);
        chk("rst_we", we, 0);
        chk("rst_addr", waddr, 0);
        chk("rst_data", wdata, 0);
        reset_b = 1'b1;
        wait_cycles(2);

        // single 4x4 matrix, bytes 1..16
        clear_log();
        d0 = done_cnt;
        stream.delete();
        stream.push_back(8'd4);
        for (int k = 1; k <= 16; k++) stream.push_back(8'(k));
        pulse_start();
        chk("t1_busy", loader_busy, 1);
        chk("t1_ready", s_ready, 1);
        foreach (stream[i]) send_byte(stream[i], 0);
        finish_image();
        build_expected();
        compare_log("t1");
        if (log_d.size() > 9) begin
            chk("t1_word1", log_d[1], 16'h0102);
            chk("t1_word8", log_d[8], 16'h0F10);
            chk("t1_term", log_d[9], 16'hFFFF);
        end
        chk("t1_done", done_cnt - d0, 1);
        chk("t1_count", matrix_count, 1);
        chk("t1_busy_end", loader_busy, 0);

        // N=4 then N=6 with s_valid held high; must take exactly one cycle per byte
        clear_log();
        stream.delete();
        add_matrix(4, 0);
        add_matrix(6, 0);
        pulse_start();
        c0 = cyc;
        foreach (stream[i]) send_byte(stream[i], 0);
        chk("t2_cycles", cyc - c0, 54);
        finish_image();
        build_expected();
        compare_log("t2");
        if (log_d.size() > 28) begin
            chk("t2_hdr9", log_d[9], 16'h0006);
            chk("t2_term_addr", log_a[28], 28);
        end
        chk("t2_count", matrix_count, 2);

        // header legality table
        for (int v = 0; v < 12; v++) begin
            clear_log();
            pulse_start();
            send_byte(hv[v].n, 0);
            wait_cycles(1);
            chk($sformatf("hdr%0d_err", hv[v].n), loader_error, hv[v].exp_err);
            chk($sformatf("hdr%0d_ready", hv[v].n), s_ready, !hv[v].exp_err);
            chk($sformatf("hdr%0d_busy", hv[v].n), loader_busy, !hv[v].exp_err);
            chk($sformatf("hdr%0d_nwr", hv[v].n), log_a.size(), hv[v].exp_err ? 0 : 1);
            if (!hv[v].exp_err) begin
                if (log_d.size() > 0) chk($sformatf("hdr%0d_word", hv[v].n), log_d[0], {8'h00, hv[v].n});
                finish_image();
                chk($sformatf("hdr%0d_trunc_err", hv[v].n), loader_error, 1);
            end
        end
        pulse_start();
        chk("err_cleared", loader_error, 0);

        // truncation after 3 pixels, then finish colliding with a byte in GET_N
        clear_log();
        d0 = done_cnt;
        send_byte(8'd4, 0);
        send_byte(8'd1, 0);
        send_byte(8'd2, 0);
        send_byte(8'd3, 0);
        finish_image();
        chk("t4_err", loader_error, 1);
        chk("t4_nwr", log_a.size(), 2);
        chk("t4_done", done_cnt - d0, 0);
        clear_log();
        pulse_start();
        s_valid     = 1'b1;
        s_data      = 8'd4;
        load_finish = 1'b1;
        #1;
        chk("t4_ready_fin", s_ready, 0);
        step();
        s_valid     = 1'b0;
        load_finish = 1'b0;
        wait_cycles(3);
        chk("t4_term_nwr", log_a.size(), 1);
        if (log_d.size() > 0) begin
            chk("t4_term_data", log_d[0], 16'hFFFF);
            chk("t4_term_addr", log_a[0], BASE);
        end
        chk("t4_term_done", done_cnt - d0, 1);
        chk("t4_term_count", matrix_count, 0);

        // asynchronous reset while in PIX_LO
        clear_log();
        pulse_start();
        send_byte(8'd4, 0);
        send_byte(8'd1, 0);
        send_byte(8'd2, 0);
        send_byte(8'd3, 0);
        chk("t6_pre_addr", waddr, 1);
        chk("t6_pre_data", wdata, 16'h0102);
        #2;
        reset_b = 1'b0;
        #1;
        chk("t6_we", we, 0);
        chk("t6_addr", waddr, 0);
        chk("t6_data", wdata, 0);
        chk("t6_busy", loader_busy, 0);
        chk("t6_ready", s_ready, 0);
        reset_b = 1'b1;
        wait_cycles(2);
        clear_log();
        stream.delete();
        add_matrix(4, 1);
        run_stream(1);
        build_expected();
        compare_log("t6");

        // randomized streams with valid gaps
        for (int it = 0; it < 6; it++) begin
            clear_log();
            d0 = done_cnt;
            stream.delete();
            for (int m = 0; m < int'($urandom_range(1, 3)); m++)
                add_matrix(2 * int'($urandom_range(2, 5)), (m == 0) ? 1 : 0);
            run_stream(3);
            build_expected();
            compare_log($sformatf("rnd%0d", it));
            chk($sformatf("rnd%0d_count", it), matrix_count, exp_mats);
            chk($sformatf("rnd%0d_done", it), done_cnt - d0, 1);
            chk($sformatf("rnd%0d_err", it), loader_error, 0);
        end

        // space check: second 64x64 header no longer fits
        clear_log();
        stream.delete();
        add_matrix(64, 0);
        pulse_start();
        foreach (stream[i]) send_byte(stream[i], 0);
        send_byte(8'd64, 0);
        wait_cycles(2);
        chk("ovf_err", loader_error, 1);
        chk("ovf_ready", s_ready, 0);
        chk("ovf_nwr", log_a.size(), 2049);
        chk("ovf_count", matrix_count, 1);

        // exact fill: image ends with terminator at the last SRAM word
        clear_log();
        stream.delete();
        add_matrix(64, 0);
        add_matrix(62, 0);
        for (int m = 0; m < 6; m++) add_matrix(6, 0);
        add_matrix(4, 1);
        run_stream(0);
        build_expected();
        compare_log("fill");
        chk("fill_count", matrix_count, 9);
        chk("fill_err", loader_error, 0);
        if (log_a.size() > 0) chk("fill_last_addr", log_a[log_a.size() - 1], 4095);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
